// File: rtl/kbd_in_buffer.sv
// kbd_in_buffer
//   Keyboard input stage in front of the cpu's keyboard port. Keystroke
//   strobes are captured into a small FIFO. The oldest character and the
//   input flag (fgi) are presented to the cpu. The cpu pops the head with a
//   one-cycle inp_ack pulse when it executes INP.
//
//   Optional feature macro: KBD_PARITY_EN
//     When defined, a key_par input is present and keys must carry odd parity.
//     Bad-parity keys are dropped and set par_err.
//     When undefined, par_err is tied to 0.
//
// Ports
//   clk       system clock, rising edge
//   rst       synchronous active-low reset
//   key_valid one-cycle strobe, key_data holds a new character
//   key_data  character code from the key source
//   key_par   odd-parity bit for key_data (KBD_PARITY_EN only)
//   inp_ack   one-cycle pulse, head character consumed by the cpu
//   en_inp    cpu input-interrupt enable
//   err_clr   clears the sticky error flags
//   keyboard  head character, 8'h00 when empty
//   fgi       input flag, FIFO non-empty
//   intr      interrupt request, fgi & en_inp
//   count     number of stored characters, 0..DEPTH
//   ovf       sticky overflow, a key was dropped while full
//   par_err   sticky parity error
module kbd_in_buffer #(
   parameter int DEPTH = 4,
   parameter int AW    = 2
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          key_valid,
   input  logic [7:0]    key_data,
`ifdef KBD_PARITY_EN
   input  logic          key_par,
`endif
   input  logic          inp_ack,
   input  logic          en_inp,
   input  logic          err_clr,
   output logic [7:0]    keyboard,
   output logic          fgi,
   output logic          intr,
   output logic [AW:0]   count,
   output logic          ovf,
   output logic          par_err
);

   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count_nxt;
   logic          par_ok;
   logic          full;
   logic          do_push;
   logic          do_pop;
   logic          ovf_set;
   logic          par_set;

`ifdef KBD_PARITY_EN
   assign par_ok = ^{key_par, key_data};
`else
   assign par_ok = 1'b1;
`endif

   assign full    = (count == FULL_CNT);
   // fgi mirrors count != 0, so an ack while empty is ignored here.
   assign do_pop  = inp_ack & fgi;
   // When full, a simultaneous pop frees the slot for the incoming key.
   assign do_push = key_valid & par_ok & (~full | do_pop);
   // Overflow depends only on occupancy, so a bad-parity key arriving
   // while full sets both flags.
   assign ovf_set = key_valid & full & ~do_pop;
   assign par_set = key_valid & ~par_ok;

   always_comb begin
      count_nxt = count;
      case ({do_push, do_pop})
         2'b10:   count_nxt = count + 1'b1;
         2'b01:   count_nxt = count - 1'b1;
         default: count_nxt = count;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         fgi    <= 1'b0;
         ovf    <= 1'b0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         count <= count_nxt;
         fgi   <= (count_nxt != '0);
         ovf   <= ovf_set | (ovf & ~err_clr);
      end
   end

   // Storage is not reset; fgi masks stale contents on the output.
   always_ff @(posedge clk) begin
      if (rst && do_push) mem[wr_ptr] <= key_data;
   end

`ifdef KBD_PARITY_EN
   always_ff @(posedge clk) begin
      if (!rst) par_err <= 1'b0;
      else      par_err <= par_set | (par_err & ~err_clr);
   end
`else
   assign par_err = 1'b0;
   logic unused_par;
   assign unused_par = par_set;
`endif

   assign keyboard = fgi ? mem[rd_ptr] : 8'h00;
   assign intr     = fgi & en_inp;

endmodule

// File: tb/tb_kbd_in_buffer.sv
module tb_kbd_in_buffer;

   logic       clk = 1'b0;
   logic       rst;
   logic       key_valid;
   logic [7:0] key_data;
`ifdef KBD_PARITY_EN
   logic       key_par;
`endif
   logic       inp_ack;
   logic       en_inp;
   logic       err_clr;
   logic [7:0] keyboard;
   logic       fgi;
   logic       intr;
   logic [2:0] count;
   logic       ovf;
   logic       par_err;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   kbd_in_buffer #(.DEPTH(4), .AW(2)) dut (
      .clk(clk),
      .rst(rst),
      .key_valid(key_valid),
      .key_data(key_data),
`ifdef KBD_PARITY_EN
      .key_par(key_par),
`endif
      .inp_ack(inp_ack),
      .en_inp(en_inp),
      .err_clr(err_clr),
      .keyboard(keyboard),
      .fgi(fgi),
      .intr(intr),
      .count(count),
      .ovf(ovf),
      .par_err(par_err)
   );

   // Inputs change #1 after the rising edge; outputs are sampled there too.
   task automatic tick();
      @(posedge clk);
      #1;
      key_valid = 1'b0;
      inp_ack   = 1'b0;
      err_clr   = 1'b0;
   endtask

   task automatic push(input logic [7:0] d, input logic ack);
      key_valid = 1'b1;
      key_data  = d;
`ifdef KBD_PARITY_EN
      key_par   = ~(^d);
`endif
      inp_ack   = ack;
      tick();
   endtask

   task automatic ack();
      inp_ack = 1'b1;
      tick();
   endtask

   task automatic test_reset();
      rst = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      tick();
      checks++; if (keyboard !== 8'h00) begin errors++; $display("FAIL reset_keyboard got %h exp 00", keyboard); end
      checks++; if (fgi !== 1'b0) begin errors++; $display("FAIL reset_fgi got %b exp 0", fgi); end
      checks++; if (intr !== 1'b0) begin errors++; $display("FAIL reset_intr got %b exp 0", intr); end
      checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
      checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b exp 0", ovf); end
      checks++; if (par_err !== 1'b0) begin errors++; $display("FAIL reset_par_err got %b exp 0", par_err); end
   endtask

   task automatic test_single();
      en_inp = 1'b1;
      push(8'h77, 1'b0);
      checks++; if (keyboard !== 8'h77) begin errors++; $display("FAIL single_keyboard got %h exp 77", keyboard); end
      checks++; if (fgi !== 1'b1) begin errors++; $display("FAIL single_fgi got %b exp 1", fgi); end
      checks++; if (intr !== 1'b1) begin errors++; $display("FAIL single_intr got %b exp 1", intr); end
      checks++; if (count !== 3'd1) begin errors++; $display("FAIL single_count got %0d exp 1", count); end
      en_inp = 1'b0;
      #1;
      checks++; if (intr !== 1'b0) begin errors++; $display("FAIL single_intr_masked got %b exp 0", intr); end
      en_inp = 1'b1;
      #1;
      ack();
      checks++; if (fgi !== 1'b0) begin errors++; $display("FAIL single_pop_fgi got %b exp 0", fgi); end
      checks++; if (keyboard !== 8'h00) begin errors++; $display("FAIL single_pop_keyboard got %h exp 00", keyboard); end
      checks++; if (intr !== 1'b0) begin errors++; $display("FAIL single_pop_intr got %b exp 0", intr); end
   endtask

   task automatic test_fill_overflow();
      logic [7:0] exp_q [4];
      exp_q = '{8'h99, 8'h77, 8'h88, 8'hEE};
      for (int i = 0; i < 4; i++) push(exp_q[i], 1'b0);
      checks++; if (count !== 3'd4) begin errors++; $display("FAIL fill_count got %0d exp 4", count); end
      checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL fill_ovf_early got %b exp 0", ovf); end
      push(8'h11, 1'b0);
      checks++; if (count !== 3'd4) begin errors++; $display("FAIL ovf_count got %0d exp 4", count); end
      checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b exp 1", ovf); end
      for (int i = 0; i < 4; i++) begin
         checks++; if (keyboard !== exp_q[i]) begin errors++; $display("FAIL fill_read%0d got %h exp %h", i, keyboard, exp_q[i]); end
         ack();
      end
      checks++; if (count !== 3'd0) begin errors++; $display("FAIL fill_drain_count got %0d exp 0", count); end
      checks++; if (keyboard !== 8'h00) begin errors++; $display("FAIL fill_drain_keyboard got %h exp 00", keyboard); end
      checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b exp 1", ovf); end
      err_clr = 1'b1;
      tick();
      checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL ovf_clear got %b exp 0", ovf); end
   endtask

   task automatic test_push_pop_full();
      logic [7:0] exp_q [4];
      for (int i = 0; i < 4; i++) push(8'hA0 + 8'(i), 1'b0);
      push(8'h55, 1'b1);
      checks++; if (count !== 3'd4) begin errors++; $display("FAIL pp_full_count got %0d exp 4", count); end
      checks++; if (keyboard !== 8'hA1) begin errors++; $display("FAIL pp_full_head got %h exp A1", keyboard); end
      checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL pp_full_ovf got %b exp 0", ovf); end
      // Overflow set and clear in the same cycle: set must win.
      err_clr = 1'b1;
      push(8'h66, 1'b0);
      checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_set_wins got %b exp 1", ovf); end
      err_clr = 1'b1;
      tick();
      checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL ovf_clear2 got %b exp 0", ovf); end
      exp_q = '{8'hA1, 8'hA2, 8'hA3, 8'h55};
      for (int i = 0; i < 4; i++) begin
         checks++; if (keyboard !== exp_q[i]) begin errors++; $display("FAIL wrap_read%0d got %h exp %h", i, keyboard, exp_q[i]); end
         ack();
      end
      checks++; if (count !== 3'd0) begin errors++; $display("FAIL wrap_drain_count got %0d exp 0", count); end
   endtask

   task automatic test_ack_empty();
      ack();
      checks++; if (count !== 3'd0) begin errors++; $display("FAIL ack_empty_count got %0d exp 0", count); end
      checks++; if (fgi !== 1'b0) begin errors++; $display("FAIL ack_empty_fgi got %b exp 0", fgi); end
      checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL ack_empty_ovf got %b exp 0", ovf); end
      push(8'h3C, 1'b1);
      checks++; if (count !== 3'd1) begin errors++; $display("FAIL empty_pp_count got %0d exp 1", count); end
      checks++; if (keyboard !== 8'h3C) begin errors++; $display("FAIL empty_pp_keyboard got %h exp 3C", keyboard); end
      ack();
      checks++; if (count !== 3'd0) begin errors++; $display("FAIL empty_pp_drain got %0d exp 0", count); end
   endtask

   task automatic test_reset_midstream();
      for (int i = 1; i <= 5; i++) push(8'(i), 1'b0);
      ack();
      checks++; if (count !== 3'd3) begin errors++; $display("FAIL mid_count got %0d exp 3", count); end
      checks++; if (keyboard !== 8'h02) begin errors++; $display("FAIL mid_head got %h exp 02", keyboard); end
      checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL mid_ovf got %b exp 1", ovf); end
      rst = 1'b0;
      push(8'h09, 1'b1);
      rst = 1'b1;
      checks++; if (count !== 3'd0) begin errors++; $display("FAIL mid_rst_count got %0d exp 0", count); end
      checks++; if (fgi !== 1'b0) begin errors++; $display("FAIL mid_rst_fgi got %b exp 0", fgi); end
      checks++; if (keyboard !== 8'h00) begin errors++; $display("FAIL mid_rst_keyboard got %h exp 00", keyboard); end
      checks++; if (intr !== 1'b0) begin errors++; $display("FAIL mid_rst_intr got %b exp 0", intr); end
      checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL mid_rst_ovf got %b exp 0", ovf); end
      tick();
      checks++; if (count !== 3'd0) begin errors++; $display("FAIL mid_rst_idle_count got %0d exp 0", count); end
   endtask

`ifdef KBD_PARITY_EN
   task automatic test_parity();
      key_valid = 1'b1; key_data = 8'h77; key_par = 1'b1;
      tick();
      checks++; if (count !== 3'd1) begin errors++; $display("FAIL par_good_count got %0d exp 1", count); end
      checks++; if (par_err !== 1'b0) begin errors++; $display("FAIL par_good_err got %b exp 0", par_err); end
      key_valid = 1'b1; key_data = 8'h77; key_par = 1'b0;
      tick();
      checks++; if (count !== 3'd1) begin errors++; $display("FAIL par_bad_count got %0d exp 1", count); end
      checks++; if (par_err !== 1'b1) begin errors++; $display("FAIL par_bad_err got %b exp 1", par_err); end
      ack();
      err_clr = 1'b1;
      tick();
      checks++; if (par_err !== 1'b0) begin errors++; $display("FAIL par_clear got %b exp 0", par_err); end
   endtask
`endif

   initial begin
      rst = 1'b0; key_valid = 1'b0; key_data = 8'h00; inp_ack = 1'b0;
      en_inp = 1'b0; err_clr = 1'b0;
`ifdef KBD_PARITY_EN
      key_par = 1'b1;
`endif
      #1;
      test_reset();
      test_single();
      test_fill_overflow();
      test_push_pop_full();
      test_ack_empty();
      test_reset_midstream();
`ifdef KBD_PARITY_EN
      test_parity();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
